ff_write_arbiter: RTL and testbench
===================================

# ff_write_arbiter

Round-robin write arbiter that shares one WIDTH-bit register built from `ff_d_sinc` cells between N requesters. It drives the register's enable and data inputs, serialises competing writes, and returns a one-cycle acknowledge to each requester whose write has committed. It sits between the crypto datapath stages, such as key/state update units, and a shared holding register.

## Interface
- `N`, 4: number of requesters (2..8).
- `WIDTH`, 8: register data width.
- `LOCK_MAX`, 4: maximum consecutive locked writes per requester (used only with `FF_ARB_LOCK_EN`).

- `clk`  in  1: clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N: write request, one bit per requester.
- `wdata`  in  N*WIDTH: requester i data at `[i*WIDTH +: WIDTH]`.
- `lock`  in  N: burst-hold request, one bit per requester. Ignored without the macro.
- `gnt`  out  N: one-hot grant, registered.
- `ack`  out  N: one-cycle write-committed pulse, registered.
- `ff_en`  out  1: register enable, connects to the `en` of the `ff_d_sinc` cells.
- `ff_d`  out  WIDTH: register data, connects to `d` of the cells.
- `busy`  out  1: high in WRITE and ACK.

## Operation
- Reset values: `gnt`=0, `ack`=0, `ff_en`=0, `ff_d`=0, `busy`=0. Round-robin pointer `ptr`=0. State IDLE.
- States and transitions:
  - IDLE: if `req`!=0, go to WRITE.
  - WRITE: always go to ACK after one cycle.
  - ACK: go to IDLE. With the macro, ACK can go directly back to WRITE (see Configuration).
- Arbitration runs in IDLE only:
  - Search order is `ptr`, `ptr`+1, …, wrapping from N-1 to 0. The first set `req` bit wins.
  - The winner's `wdata` slice is captured into `ff_d` at the same edge.
- WRITE: `gnt`=one-hot winner, `ff_en`=1, `ff_d` holds the captured data.
- ACK: `ff_en`=0, `ack[winner]`=1, `gnt` held. `ptr` ← (winner+1) mod N, updated at the ACK-entry edge.
- `req` deasserted during WRITE: the write still completes and is acked, because the data was already captured.
- `req` still high in ACK: ignored in that cycle. It is evaluated again in IDLE as a new request.
- `wdata` changes after the capture edge have no effect on the write in progress.
- Reset in any state returns to the reset values at the next edge:
  - No ack is issued.
  - `ff_en` is 0 after that edge.
- Invalid state encodings recover to IDLE.

## Timing
- E0 is the edge at which IDLE samples `req`!=0.
  - After E0: state WRITE; `gnt`, `ff_en`=1 and `ff_d` are valid.
  - At E1: the register captures `ff_d`. After E1: state ACK, `ack` pulses and `q` shows the new value.
  - After E2: state IDLE; `gnt` and `ack` are 0.
- The earliest next grant is visible after E3. Unlocked throughput is one write per 3 cycles.
- Latency from `req` sampled to `ack` is 2 cycles.
- `ack` and `ff_en` are never high in the same cycle.
- `gnt` is at most one-hot in every cycle.

## Configuration
- `FF_ARB_LOCK_EN` defined:
  - In ACK, if `lock[winner]` and `req[winner]` are both high and the locked-write count is below `LOCK_MAX`, the next state is WRITE with the same winner.
  - New `wdata` is captured at that edge, `ptr` is not advanced, and the count increments.
  - This gives one write per 2 cycles.
  - When the count reaches `LOCK_MAX`, the block goes to IDLE, `ptr` advances and the count clears.
  - The count also clears in IDLE.
- Not defined: the `lock` port exists but is unused, and ACK always goes to IDLE.

## Test plan
- Reset held for 2 cycles with random `req`: all outputs are 0 throughout, and the first grant after reset release goes to the lowest set `req` index.
- Single request, `req`=4'b0100, `wdata[2]`=8'hA5:
  - After E0: `gnt`=4'b0100, `ff_en`=1, `ff_d`=8'hA5.
  - After E1: `ack`=4'b0100 and `q`=8'hA5.
  - After E2: everything returns to 0.
- `req`=4'b1111 held continuously with distinct data per requester: grants go 0,1,2,3,0 at 3-cycle spacing, and each `q` value matches the granted requester.
- `ptr`=2 (after a write by requester 1), then `req`=4'b1010: requester 3 wins first, then requester 1, with the wrap from 3 to 0 checked.
- `reset` asserted during WRITE for requester 0: no `ack` pulse, `ff_en`=0 after that edge, and the next grant search starts from index 0.
- `FF_ARB_LOCK_EN`, `req`=4'b0011, `lock`=4'b0001, `LOCK_MAX`=4:
  - Requester 0 gets 4 writes at 2-cycle spacing.
  - Then requester 1 is granted and `ptr`=2 after its ack.
  - Without the macro, the same stimulus alternates between requesters 0 and 1.

Source files
------------

// File: rtl/ff_write_arbiter.sv
// Purpose : round-robin arbiter sharing one WIDTH-bit ff_d_sinc holding register among N writers.
// Latency : req sampled in IDLE -> ff_en next cycle -> ack one cycle later (2 cycles req-to-ack).
// Backpr. : no flow control on req; losers simply keep req high and are re-arbitrated in IDLE.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req[N]            write request per requester
//   wdata[N*WIDTH]    requester i data at [i*WIDTH +: WIDTH]
//   lock[N]           burst-hold request (only used when FF_ARB_LOCK_EN is defined)
//   gnt[N]            registered one-hot grant, held through WRITE and ACK
//   ack[N]            registered one-cycle pulse when the winner's write has committed
//   ff_en, ff_d       enable and data for the shared ff_d_sinc register
//   busy              high while in WRITE or ACK
//
// Optional feature: define FF_ARB_LOCK_EN to let a locked winner chain up to
// LOCK_MAX writes back to back (ACK -> WRITE) without re-arbitration.

module ff_write_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic                 ff_en,
    output logic [WIDTH-1:0]     ff_d,
    output logic                 busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;       // first index searched at the next arbitration
    logic [PW-1:0]   win;       // requester owning the current write
    logic [PW-1:0]   arb_idx;
    logic            arb_hit;
    logic [PW-1:0]   ptr_inc;
    logic            lock_go;

    // Per-requester view of the flat data bus.
    logic [WIDTH-1:0] wd_arr [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wd_arr[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Rotating priority search starting at ptr. The loop runs from the
    // farthest offset down to offset 0 so the nearest set request is the
    // last assignment and therefore wins. The sum is one bit wider than ptr
    // so ptr + offset never overflows before the wrap subtraction.
    logic [PW:0] sum;
    logic [PW-1:0] idx;

    always_comb begin
        arb_idx = '0;
        arb_hit = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (req[idx]) begin
                arb_idx = idx;
                arb_hit = 1'b1;
            end
        end
    end

    // Pointer moves to the requester after the winner, wrapping at N-1.
    assign ptr_inc = (win == PW'(N - 1)) ? '0 : win + PW'(1);

`ifdef FF_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    // Number of writes performed by the current winner in this burst,
    // including the one that came from IDLE.
    logic [CW-1:0] lock_cnt;

    assign lock_go = lock[win] && req[win] && (lock_cnt < CW'(LOCK_MAX));
`else
    logic unused_lock;

    assign unused_lock = ^lock ^ (LOCK_MAX > 0);
    assign lock_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            gnt   <= '0;
            ack   <= '0;
            ff_en <= 1'b0;
            ff_d  <= '0;
            busy  <= 1'b0;
`ifdef FF_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (arb_hit) begin
                        // Data is captured here, so later wdata or req
                        // changes cannot disturb this write.
                        state <= WRITE;
                        win   <= arb_idx;
                        gnt   <= onehot(arb_idx);
                        ff_en <= 1'b1;
                        ff_d  <= wd_arr[arb_idx];
                        busy  <= 1'b1;
`ifdef FF_ARB_LOCK_EN
                        lock_cnt <= CW'(1);
`endif
                    end else begin
                        gnt   <= '0;
                        ff_en <= 1'b0;
                        ff_d  <= '0;
                        busy  <= 1'b0;
`ifdef FF_ARB_LOCK_EN
                        lock_cnt <= '0;
`endif
                    end
                end

                WRITE: begin
                    // The register commits ff_d on this edge; report it.
                    state <= ACK;
                    ff_en <= 1'b0;
                    ack   <= onehot(win);
                    ptr   <= ptr_inc;
                end

                ACK: begin
                    ack <= '0;
                    if (lock_go) begin
                        // Chained write for the same owner. ptr already
                        // points past this winner, so it stays put.
                        state <= WRITE;
                        ff_en <= 1'b1;
                        ff_d  <= wd_arr[win];
`ifdef FF_ARB_LOCK_EN
                        lock_cnt <= lock_cnt + CW'(1);
`endif
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        ff_en <= 1'b0;
                        ff_d  <= '0;
                        busy  <= 1'b0;
`ifdef FF_ARB_LOCK_EN
                        lock_cnt <= '0;
`endif
                    end
                end

                default: begin
                    // Unreachable encoding: drop everything and re-arbitrate.
                    state <= IDLE;
                    gnt   <= '0;
                    ack   <= '0;
                    ff_en <= 1'b0;
                    ff_d  <= '0;
                    busy  <= 1'b0;
`ifdef FF_ARB_LOCK_EN
                    lock_cnt <= '0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Purpose : self-checking bench for ff_write_arbiter (vector table, directed corners, random vs model).
// Latency : one tick = one clock edge; outputs sampled 1 time unit after the rising edge.
// Backpr. : none; the bench drives req/lock/wdata freely every cycle.

module tb_ff_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LM = 4;

    localparam logic [N*W-1:0] WD = 32'hD3C2_B1A0;
    localparam logic [N*W-1:0] WS = 32'h11A5_2233;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           ff_en;
    logic [W-1:0]   ff_d;
    logic           busy;
    logic [W-1:0]   q;

    always #5 clk = ~clk;

    ff_write_arbiter #(.N(N), .WIDTH(W), .LOCK_MAX(LM)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .lock  (lock),
        .gnt   (gnt),
        .ack   (ack),
        .ff_en (ff_en),
        .ff_d  (ff_d),
        .busy  (busy)
    );

    // Stand-in for the shared ff_d_sinc register driven by the arbiter.
    always @(posedge clk) begin
        if (reset)      q <= '0;
        else if (ff_en) q <= ff_d;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- reference model (timeline of expected outputs) ----------------
    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic         en;
        logic [W-1:0] d;
        logic         busy;
        logic         chk_d;
    } exp_t;

    exp_t ring [4];
    exp_t cur;
    int   ec          = 0;   // index of the next clock edge
    int   m_ptr       = 0;
    int   m_free      = 0;   // first edge at which a new arbitration may happen
    int   m_lock_edge = -1;  // edge that leaves the ack cycle of the current write
    int   m_w         = 0;
    int   m_cnt       = 0;

    task automatic sched(input int e, input int w, input logic [N*W-1:0] wd);
        exp_t x;
        x       = '0;
        x.gnt   = N'(1) << w;
        x.en    = 1'b1;
        x.d     = wd[w*W +: W];
        x.busy  = 1'b1;
        x.chk_d = 1'b1;
        ring[e % 4] = x;
        x       = '0;
        x.gnt   = N'(1) << w;
        x.ack   = N'(1) << w;
        x.busy  = 1'b1;
        ring[(e + 1) % 4] = x;
        m_free      = e + 3;
        m_lock_edge = e + 2;
        m_w         = w;
    endtask

    task automatic model_edge(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] lk,
                              input logic [N*W-1:0] wd);
        int w;
        if (rst) begin
            for (int i = 0; i < 4; i++) ring[i] = '0;
            m_ptr       = 0;
            m_free      = ec + 1;
            m_lock_edge = -1;
            m_cnt       = 0;
        end else if (ec >= m_free && rq != 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            sched(ec, w, wd);
            m_ptr = (w + 1) % N;
            m_cnt = 1;
        end
`ifdef FF_ARB_LOCK_EN
        else if (ec == m_lock_edge && lk[m_w] && rq[m_w] && m_cnt < LM) begin
            sched(ec, m_w, wd);
            m_cnt++;
        end
`endif
    endtask

    task automatic tick(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N*W-1:0] wd);
        model_edge(rst, rq, lk, wd);
        cur = ring[ec % 4];
        ring[ec % 4] = '0;
        ec++;
        reset = rst;
        req   = rq;
        lock  = lk;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".gnt"},  32'(gnt),   32'(cur.gnt));
        check({tag, ".ack"},  32'(ack),   32'(cur.ack));
        check({tag, ".en"},   32'(ff_en), 32'(cur.en));
        check({tag, ".busy"}, 32'(busy),  32'(cur.busy));
        if (cur.chk_d || !cur.busy) check({tag, ".ff_d"}, 32'(ff_d), 32'(cur.d));
        check({tag, ".onehot"},  32'($countones(gnt) <= 1), 32'd1);
        check({tag, ".ack_en"},  32'((ack != 0) && ff_en), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        logic [N*W-1:0] wd;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic         e;
        logic [W-1:0] d;
        logic         b;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd,
                                input logic [N-1:0] g, input logic [N-1:0] a, input logic e,
                                input logic [W-1:0] d, input logic b);
        vec_t v;
        v.rst = r; v.rq = rq; v.wd = wd; v.g = g; v.a = a; v.e = e; v.d = d; v.b = b;
        return v;
    endfunction

    vec_t vt [22];

    initial begin
        int           gl [$];
        int           gc [$];
        int           acks;
        logic [W-1:0] last_d;
        int           exp_w [$];
        int           exp_c [$];

        for (int i = 0; i < 4; i++) ring[i] = '0;
        last_d = '0;

        // Reset held two cycles, then lowest-index grant; single write; pointer wrap;
        // reset during WRITE.
        vt[0]  = mk(1, 4'b1010, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[1]  = mk(1, 4'b0110, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[2]  = mk(0, 4'b0110, WD, 4'b0010, 4'b0000, 1, 8'hB1, 1);
        vt[3]  = mk(0, 4'b0000, WD, 4'b0010, 4'b0010, 0, 8'h00, 1);
        vt[4]  = mk(0, 4'b0000, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[5]  = mk(0, 4'b0100, WS, 4'b0100, 4'b0000, 1, 8'hA5, 1);
        vt[6]  = mk(0, 4'b0100, WS, 4'b0100, 4'b0100, 0, 8'h00, 1);
        vt[7]  = mk(0, 4'b0000, WS, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[8]  = mk(0, 4'b0010, WD, 4'b0010, 4'b0000, 1, 8'hB1, 1);
        vt[9]  = mk(0, 4'b1010, WD, 4'b0010, 4'b0010, 0, 8'h00, 1);
        vt[10] = mk(0, 4'b1010, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[11] = mk(0, 4'b1010, WD, 4'b1000, 4'b0000, 1, 8'hD3, 1);
        vt[12] = mk(0, 4'b1010, WD, 4'b1000, 4'b1000, 0, 8'h00, 1);
        vt[13] = mk(0, 4'b1010, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[14] = mk(0, 4'b1010, WD, 4'b0010, 4'b0000, 1, 8'hB1, 1);
        vt[15] = mk(0, 4'b0000, WD, 4'b0010, 4'b0010, 0, 8'h00, 1);
        vt[16] = mk(0, 4'b0000, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[17] = mk(0, 4'b0001, WD, 4'b0001, 4'b0000, 1, 8'hA0, 1);
        vt[18] = mk(1, 4'b0001, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);
        vt[19] = mk(0, 4'b0110, WD, 4'b0010, 4'b0000, 1, 8'hB1, 1);
        vt[20] = mk(0, 4'b0000, WD, 4'b0010, 4'b0010, 0, 8'h00, 1);
        vt[21] = mk(0, 4'b0000, WD, 4'b0000, 4'b0000, 0, 8'h00, 0);

        for (int i = 0; i < 22; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            tick(vt[i].rst, vt[i].rq, 4'b0000, vt[i].wd);
            check({t, ".gnt"},  32'(gnt),   32'(vt[i].g));
            check({t, ".ack"},  32'(ack),   32'(vt[i].a));
            check({t, ".en"},   32'(ff_en), 32'(vt[i].e));
            check({t, ".busy"}, 32'(busy),  32'(vt[i].b));
            if (vt[i].e || !vt[i].b) check({t, ".ff_d"}, 32'(ff_d), 32'(vt[i].d));
            if (vt[i].e) last_d = vt[i].d;
            if (vt[i].a != 0) check({t, ".q"}, 32'(q), 32'(last_d));
        end

        // Continuous 4'b1111: rotation 0,1,2,3,0 at 3-cycle spacing, q follows the winner.
        tick(1, 4'b1111, 4'b0000, WD);
        cmp_model("rr.rst");
        acks = 0;
        for (int c = 0; c < 15; c++) begin
            tick(0, 4'b1111, 4'b0000, WD);
            cmp_model($sformatf("rr%0d", c));
            if (ff_en) begin
                gl.push_back(oh2i(gnt));
                gc.push_back(c);
            end
            if (ack != 0) begin
                check("rr.q", 32'(q), 32'(WD[(acks % N)*W +: W]));
                acks++;
            end
        end
        check("rr.count", 32'(gl.size()), 32'd5);
        for (int i = 0; i < gl.size() && i < 5; i++) begin
            check($sformatf("rr.win%0d", i), 32'(gl[i]), 32'(i % N));
            check($sformatf("rr.cyc%0d", i), 32'(gc[i]), 32'(3 * i));
        end

        // Locked burst: req=0011 lock=0001, then req=0111 to probe where ptr landed.
        gl.delete();
        gc.delete();
`ifdef FF_ARB_LOCK_EN
        exp_w = '{0, 0, 0, 0, 1, 2};
        exp_c = '{0, 2, 4, 6, 9, 12};
`else
        exp_w = '{0, 1, 0, 1, 2};
        exp_c = '{0, 3, 6, 9, 12};
`endif
        tick(1, 4'b0000, 4'b0000, WD);
        cmp_model("lk.rst");
        for (int c = 0; c < 14; c++) begin
            logic [N*W-1:0] wd;
            wd = {$urandom};
            if (c < 12) tick(0, 4'b0011, 4'b0001, wd);
            else        tick(0, 4'b0111, 4'b0000, wd);
            cmp_model($sformatf("lk%0d", c));
            if (ff_en) begin
                gl.push_back(oh2i(gnt));
                gc.push_back(c);
            end
        end
        check("lk.count", 32'(gl.size()), 32'(exp_w.size()));
        for (int i = 0; i < gl.size() && i < exp_w.size(); i++) begin
            check($sformatf("lk.win%0d", i), 32'(gl[i]), 32'(exp_w[i]));
            check($sformatf("lk.cyc%0d", i), 32'(gc[i]), 32'(exp_c[i]));
        end

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 800; c++) begin
            logic         r;
            logic [N-1:0] rq;
            logic [N-1:0] lk;
            r  = ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            lk = 4'($urandom_range(0, 15));
            tick(r, rq, lk, {$urandom});
            cmp_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
